type_decoder_pipelined: RTL and testbench

Registered, parametrised successor to the combinational opcode type decoder; forms the ID-stage decode register of the 5-stage RV32I pipeline. Accepts one instruction per cycle under a valid/ready handshake. Emits a one-hot instruction-type vector, register indices and funct fields, plus an illegal-instruction flag, with 1-cycle latency. Supports stall, flush, optional FENCE/SYSTEM and M-extension decode, and a saturating illegal-instruction counter.

---
 rtl/type_decoder_pipelined.sv | 124 ++++++++++++
 tb/tb_type_decoder_pipelined.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/type_decoder_pipelined.sv
// ID-stage decode register for the RV32I pipeline: one instruction per cycle in,
// registered one-hot type, operand fields and illegal flag out one cycle later.
module type_decoder_pipelined #(
    parameter int INST_W     = 32,
    parameter int PC_W       = 32,
    parameter bit ENABLE_SYS = 1'b1,
    parameter bit ENABLE_M   = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    input  logic [PC_W-1:0]   pc,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic [10:0]       out_type,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LW     = 7'h03;
    localparam logic [6:0] OP_ADDI   = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_S      = 7'h23;
    localparam logic [6:0] OP_SB     = 7'h63;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_UJ     = 7'h6F;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        r_ok;
    logic [10:0] dec_type;
    logic        dec_illegal;
    logic        load;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    assign r_ok = (funct7 == 7'h00) || (funct7 == 7'h20) ||
                  (ENABLE_M && (funct7 == 7'h01));

    // Anything that fails its field check decodes to an all-zero type vector,
    // so illegality is simply "no type bit set".
    always_comb begin
        dec_type = '0;
        case (opcode)
            OP_R:      dec_type[0]  = r_ok;
            OP_LW:     dec_type[1]  = 1'b1;
            OP_ADDI:   dec_type[2]  = 1'b1;
            OP_JALR:   dec_type[3]  = (funct3 == 3'd0);
            OP_S:      dec_type[4]  = 1'b1;
            OP_SB:     dec_type[5]  = 1'b1;
            OP_AUIPC:  dec_type[6]  = 1'b1;
            OP_LUI:    dec_type[7]  = 1'b1;
            OP_UJ:     dec_type[8]  = 1'b1;
            OP_FENCE:  dec_type[9]  = ENABLE_SYS;
            OP_SYSTEM: dec_type[10] = ENABLE_SYS;
            default:   dec_type     = '0;
        endcase
    end

    assign dec_illegal = (dec_type == '0);
    assign in_ready    = !stall;
    assign load        = in_valid && !stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_type    <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_type    <= '0;
            out_illegal <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                out_valid   <= 1'b1;
                out_pc      <= pc;
                out_rd      <= inst[11:7];
                out_rs1     <= inst[19:15];
                out_rs2     <= inst[24:20];
                out_funct3  <= funct3;
                out_funct7  <= funct7;
                out_type    <= dec_type;
                out_illegal <= dec_illegal;
            end else begin
                out_valid   <= 1'b0;
                out_type    <= '0;
                out_illegal <= 1'b0;
            end
        end
    end

    // Saturating: once all ones the counter sticks until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (load && dec_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_type_decoder_pipelined.sv
// Bench for type_decoder_pipelined: two configurations driven in lockstep and
// compared against an opcode-table reference model.
module tb_type_decoder_pipelined;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic        rdy0, v0, il0, rdy1, v1, il1;
    logic [31:0] pc0, pc1;
    logic [4:0]  rd0, rs10, rs20, rd1, rs11, rs21;
    logic [2:0]  f30, f31;
    logic [6:0]  f70, f71;
    logic [10:0] t0, t1;
    logic [15:0] c0;
    logic [1:0]  c1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    type_decoder_pipelined #(.ENABLE_SYS(1'b1), .ENABLE_M(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .inst(inst), .pc(pc),
        .stall(stall), .flush(flush), .out_valid(v0), .out_pc(pc0), .out_rd(rd0),
        .out_rs1(rs10), .out_rs2(rs20), .out_funct3(f30), .out_funct7(f70),
        .out_type(t0), .out_illegal(il0), .illegal_cnt(c0));

    type_decoder_pipelined #(.ENABLE_SYS(1'b0), .ENABLE_M(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .inst(inst), .pc(pc),
        .stall(stall), .flush(flush), .out_valid(v1), .out_pc(pc1), .out_rd(rd1),
        .out_rs1(rs11), .out_rs2(rs21), .out_funct3(f31), .out_funct7(f71),
        .out_type(t1), .out_illegal(il1), .illegal_cnt(c1));

    // Reference model: opcode table indexed by type bit position.
    localparam logic [6:0] OPC [11] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                                        7'h17, 7'h37, 7'h6F, 7'h0F, 7'h73};
    bit          m_sys [2] = '{1'b1, 1'b0};
    bit          m_m   [2] = '{1'b0, 1'b1};
    int          m_max [2] = '{65535, 3};
    logic        m_v   [2];
    logic [10:0] m_t   [2];
    logic        m_il  [2];
    logic [31:0] m_pc  [2];
    logic [31:0] m_in  [2];
    int          m_cnt [2];

    function automatic void ref_decode(input logic [31:0] w, input bit sys, input bit m,
                                       output logic [10:0] t, output logic ill);
        int idx = -1;
        logic [6:0] f7 = w[31:25];
        for (int i = 0; i < 11; i++) if (w[6:0] == OPC[i]) idx = i;
        if (idx >= 9 && !sys) idx = -1;
        if (idx == 3 && w[14:12] != 3'd0) idx = -1;
        if (idx == 0 && !(f7 == 7'h00 || f7 == 7'h20 || (m && f7 == 7'h01))) idx = -1;
        ill = (idx < 0);
        t = ill ? 11'd0 : (11'd1 << idx);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 0; m_t[k] = 0; m_il[k] = 0; m_pc[k] = 0; m_in[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic [10:0] t;
        logic ill;
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                m_v[k] = 0; m_t[k] = 0; m_il[k] = 0;
            end else if (!stall) begin
                if (in_valid) begin
                    ref_decode(inst, m_sys[k], m_m[k], t, ill);
                    m_v[k] = 1; m_t[k] = t; m_il[k] = ill; m_pc[k] = pc; m_in[k] = inst;
                    if (ill && m_cnt[k] < m_max[k]) m_cnt[k]++;
                end else begin
                    m_v[k] = 0; m_t[k] = 0; m_il[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("valid0", 32'(v0), 32'(m_v[0]));
        chk("type0", 32'(t0), 32'(m_t[0]));
        chk("illegal0", 32'(il0), 32'(m_il[0]));
        chk("cnt0", 32'(c0), 32'(m_cnt[0]));
        chk("ready0", 32'(rdy0), 32'(!stall));
        chk("valid1", 32'(v1), 32'(m_v[1]));
        chk("type1", 32'(t1), 32'(m_t[1]));
        chk("illegal1", 32'(il1), 32'(m_il[1]));
        chk("cnt1", 32'(c1), 32'(m_cnt[1]));
        chk("ready1", 32'(rdy1), 32'(!stall));
        if (m_v[0]) begin
            chk("pc0", pc0, m_pc[0]);
            chk("fields0", {5'd0, rd0, rs10, rs20, f30, f70}, {5'd0, m_in[0][11:7], m_in[0][19:15],
                m_in[0][24:20], m_in[0][14:12], m_in[0][31:25]});
        end
        if (m_v[1]) begin
            chk("pc1", pc1, m_pc[1]);
            chk("fields1", {5'd0, rd1, rs11, rs21, f31, f71}, {5'd0, m_in[1][11:7], m_in[1][19:15],
                m_in[1][24:20], m_in[1][14:12], m_in[1][31:25]});
        end
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] a,
                        input logic s, input logic f);
        @(negedge clk);
        in_valid = v; inst = w; pc = a; stall = s; flush = f;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; stall = 0; flush = 0;
        #2 rst = 1;
        model_reset();
        #1;
        chk("rst_valid0", 32'(v0), 32'd0);
        chk("rst_cnt0", 32'(c0), 32'd0);
        chk("rst_valid1", 32'(v1), 32'd0);
        chk("rst_cnt1", 32'(c1), 32'd0);
        @(negedge clk);
        rst = 0;
        #1;
        compare_all();
        chk("rst_pc0", pc0, 32'd0);
    endtask

    initial begin
        int legal0, legal1;
        logic [31:0] w;
        model_reset();
        rst = 1;
        #12 rst = 0;
        #1;
        compare_all();
        chk("reset_pc0", pc0, 32'd0);
        chk("reset_rd0", 32'(rd0), 32'd0);

        // addi x1,x2,5
        step(1, 32'h0051_0093, 32'h100, 0, 0);
        chk("addi_type", 32'(t0), 32'h004);
        chk("addi_rd", 32'(rd0), 32'd1);
        chk("addi_rs1", 32'(rs10), 32'd2);
        chk("addi_pc", pc0, 32'h100);

        // add then jal, jal held off by a stall cycle
        step(1, 32'h0020_81B3, 32'h104, 0, 0);
        step(1, 32'h0000_006F, 32'h108, 1, 0);
        chk("stall_hold_type", 32'(t0), 32'h001);
        chk("stall_ready", 32'(rdy0), 32'd0);
        step(1, 32'h0000_006F, 32'h108, 0, 0);
        chk("jal_type", 32'(t0), 32'h100);
        step(0, 32'h0, 32'h0, 0, 0);
        chk("bubble_valid", 32'(v0), 32'd0);

        // illegal trio from reset
        do_reset();
        step(1, 32'h0000_1067, 32'h200, 0, 0);
        step(1, 32'h0000_007F, 32'h204, 0, 0);
        step(1, 32'h0220_81B3, 32'h208, 0, 0);
        chk("mul_illegal0", 32'(il0), 32'd1);
        chk("mul_type1", 32'(t1), 32'h001);
        chk("trio_cnt0", 32'(c0), 32'd3);
        chk("trio_cnt1", 32'(c1), 32'd2);

        // flush beats stall and a concurrent illegal input
        step(1, 32'h0000_007F, 32'h20C, 1, 1);
        chk("flush_valid", 32'(v0), 32'd0);
        chk("flush_cnt0", 32'(c0), 32'd3);

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) step(1, 32'h0000_007F, 32'h300 + 32'(4 * i), 0, 0);
        chk("sat_cnt1", 32'(c1), 32'd3);
        chk("sat_cnt0", 32'(c0), 32'd8);

        // async reset while stalled
        step(1, 32'h0000_0013, 32'h400, 1, 0);
        do_reset();

        // opcode sweep
        legal0 = 0; legal1 = 0;
        for (int op = 0; op < 128; op++) begin
            step(1, {25'd0, 7'(op)}, 32'(op), 0, 0);
            if (!il0) legal0++;
            if (!il1) legal1++;
        end
        chk("sweep_legal_sys1", 32'(legal0), 32'd11);
        chk("sweep_legal_sys0", 32'(legal1), 32'd9);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            if ($urandom_range(3) != 0) w[6:0] = OPC[$urandom_range(10)];
            case ($urandom_range(3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
            if ($urandom_range(1) == 0) w[14:12] = 3'd0;
            step($urandom_range(3) != 0, w, $urandom, $urandom_range(3) == 0,
                 $urandom_range(7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
